// File: rtl/adder_pkg.sv
// Shared definitions for the pipelined add/subtract unit.
//   WIDTH_DEFAULT / CHUNK_DEFAULT : default operand width and bits resolved per stage
//   OP_ADD / OP_SUB               : encoding of the Sub select
//   MODE_UNSIGNED / MODE_SIGNED   : encoding of the Signed select
//   calc_overflow()               : mode-dependent overflow from the final-stage flags
package adder_pkg;

  localparam int unsigned WIDTH_DEFAULT = 32;
  localparam int unsigned CHUNK_DEFAULT = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam logic MODE_UNSIGNED = 1'b0;
  localparam logic MODE_SIGNED   = 1'b1;

  // cmsb is the carry into the MSB. Under subtraction a clear carry means a borrow.
  function automatic logic calc_overflow(input logic sub, input logic is_signed,
                                         input logic carry, input logic cmsb);
    logic ovf;
    if (is_signed == MODE_SIGNED) begin
      ovf = cmsb ^ carry;
    end else if (sub == OP_SUB) begin
      ovf = ~carry;
    end else begin
      ovf = carry;
    end
    return ovf;
  endfunction

endpackage

// File: rtl/pipe_adder_if.sv
// Operand/result bus of pipe_adder.
//   en, a, b, sub, is_signed : request side, captured when en && ready
//   ready                    : combinational, accept || !valid
//   sum, carry, overflow     : registered result, qualified by valid
//   valid, accept            : result handshake, consumed when valid && accept
// master: upstream producer plus downstream consumer. slave: the adder.
interface pipe_adder_if
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT
);

  logic             en;
  logic             ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             sub;
  logic             is_signed;
  logic [WIDTH-1:0] sum;
  logic             carry;
  logic             overflow;
  logic             valid;
  logic             accept;

  modport master (
    output en, a, b, sub, is_signed, accept,
    input  ready, sum, carry, overflow, valid
  );

  modport slave (
    input  en, a, b, sub, is_signed, accept,
    output ready, sum, carry, overflow, valid
  );

endinterface

// File: rtl/adder_stage.sv
// One CHUNK-wide slice of the pipelined carry chain.
//   i_clk, i_rst       : clock, synchronous active-high reset
//   i_hold             : global stall, every register keeps its value
//   i_valid / o_valid  : stage valid bit
//   i_a, i_b / o_a,o_b : operands (b already inverted for subtraction)
//   i_cin / o_carry    : carry into this chunk / carry out of it
//   i_sum / o_sum      : lower chunks already resolved / with this chunk added
//   o_cmsb             : carry into the top bit of this chunk
//   i_sub, i_signed    : op and mode, carried along with the data
module adder_stage
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CHUNK = CHUNK_DEFAULT,
  parameter int unsigned IDX   = 0
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_hold,
  input  logic             i_valid,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic [WIDTH-1:0] i_sum,
  input  logic             i_sub,
  input  logic             i_signed,
  output logic             o_valid,
  output logic [WIDTH-1:0] o_a,
  output logic [WIDTH-1:0] o_b,
  output logic             o_carry,
  output logic             o_cmsb,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_sub,
  output logic             o_signed
);

  localparam int unsigned LO = IDX * CHUNK;
  localparam int unsigned HI = LO + CHUNK - 1;

  logic [CHUNK:0]   w_chunk;
  logic [WIDTH-1:0] w_sum;
  logic             w_cmsb;

  logic             r_valid;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic             r_cmsb;
  logic [WIDTH-1:0] r_sum;
  logic             r_sub;
  logic             r_signed;

  always_comb begin
    w_chunk = {1'b0, i_a[LO +: CHUNK]} + {1'b0, i_b[LO +: CHUNK]} + {{CHUNK{1'b0}}, i_cin};
    w_sum = i_sum;
    w_sum[LO +: CHUNK] = w_chunk[CHUNK-1:0];
    // Sum bit = a ^ b ^ cin, so the carry into the top bit falls out without a second adder.
    w_cmsb = i_a[HI] ^ i_b[HI] ^ w_chunk[CHUNK-1];
  end

  // Data only loads with a valid op so bubbles leave the last result visible downstream.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_valid  <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_cmsb   <= 1'b0;
      r_sum    <= '0;
      r_sub    <= 1'b0;
      r_signed <= 1'b0;
    end else if (!i_hold) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_a      <= i_a;
        r_b      <= i_b;
        r_carry  <= w_chunk[CHUNK];
        r_cmsb   <= w_cmsb;
        r_sum    <= w_sum;
        r_sub    <= i_sub;
        r_signed <= i_signed;
      end
    end
  end

  assign o_valid  = r_valid;
  assign o_a      = r_a;
  assign o_b      = r_b;
  assign o_carry  = r_carry;
  assign o_cmsb   = r_cmsb;
  assign o_sum    = r_sum;
  assign o_sub    = r_sub;
  assign o_signed = r_signed;

endmodule

// File: rtl/pipe_adder.sv
// Pipelined add/subtract unit, WIDTH bits resolved CHUNK bits per stage.
//   i_clk  : clock, all state on the rising edge
//   i_rst  : synchronous active-high reset, priority over every handshake
//   io_bus : operand/result bus (slave side), see pipe_adder_if
// Latency is WIDTH/CHUNK cycles, throughput one op per cycle, stall is global.
module pipe_adder
  import adder_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEFAULT,
  parameter int unsigned CHUNK = CHUNK_DEFAULT
) (
  input logic         i_clk,
  input logic         i_rst,
  pipe_adder_if.slave io_bus
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  // Index k carries the state leaving stage k; index 0 is the capture side.
  logic             w_valid [STAGES+1];
  logic [WIDTH-1:0] w_a     [STAGES+1];
  logic [WIDTH-1:0] w_b     [STAGES+1];
  logic             w_carry [STAGES+1];
  logic [WIDTH-1:0] w_sum   [STAGES+1];
  logic             w_sub   [STAGES+1];
  logic             w_sgn   [STAGES+1];
  logic             w_cmsb  [STAGES];
  logic             w_hold;

  assign w_hold       = w_valid[STAGES] && !io_bus.accept;
  assign io_bus.ready = !w_hold;

  // Subtraction is A + ~B + 1: invert B and feed the 1 in as the initial carry.
  assign w_valid[0] = io_bus.en && io_bus.ready;
  assign w_a[0]     = io_bus.a;
  assign w_b[0]     = io_bus.b ^ {WIDTH{io_bus.sub}};
  assign w_carry[0] = io_bus.sub;
  assign w_sum[0]   = '0;
  assign w_sub[0]   = io_bus.sub;
  assign w_sgn[0]   = io_bus.is_signed;

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    adder_stage #(
      .WIDTH (WIDTH),
      .CHUNK (CHUNK),
      .IDX   (g)
    ) u_stage (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_hold   (w_hold),
      .i_valid  (w_valid[g]),
      .i_a      (w_a[g]),
      .i_b      (w_b[g]),
      .i_cin    (w_carry[g]),
      .i_sum    (w_sum[g]),
      .i_sub    (w_sub[g]),
      .i_signed (w_sgn[g]),
      .o_valid  (w_valid[g+1]),
      .o_a      (w_a[g+1]),
      .o_b      (w_b[g+1]),
      .o_carry  (w_carry[g+1]),
      .o_cmsb   (w_cmsb[g]),
      .o_sum    (w_sum[g+1]),
      .o_sub    (w_sub[g+1]),
      .o_signed (w_sgn[g+1])
    );
  end

  assign io_bus.valid    = w_valid[STAGES];
  assign io_bus.sum      = w_sum[STAGES];
  assign io_bus.carry    = w_carry[STAGES];
  assign io_bus.overflow = calc_overflow(w_sub[STAGES], w_sgn[STAGES], w_carry[STAGES],
                                         w_cmsb[STAGES-1]);

endmodule

// File: doc/pipe_adder.md
# pipe_adder

Parametrised, pipelined add/subtract unit that generalises the team's 4-bit enabled adder to arbitrary width. The carry chain is split into CHUNK-bit slices, one per pipeline stage, so long adds close timing at high clock rates. It adds signed/unsigned overflow modes, subtraction, in-order valid/ready flow control with backpressure, and back-to-back throughput of one operation per cycle. It sits between the operand-select logic and the result writeback path.

## Interface
- WIDTH, 32, operand and result width in bits; must be a multiple of CHUNK.
- CHUNK, 8, bits resolved per pipeline stage; STAGES = WIDTH/CHUNK, which must be ≥ 1.
- Clk  in  1  single clock; all state updates on the rising edge.
- Reset  in  1  synchronous, active-high reset.
- En  in  1  input valid; the operation is captured on an edge where En && Ready.
- Ready  out  1  combinational; Ready = Accept || !Valid.
- A  in  WIDTH  first operand.
- B  in  WIDTH  second operand.
- Sub  in  1  selects the operation: 0 gives A+B, 1 gives A−B (computed as A + ~B + 1).
- Signed  in  1  selects overflow mode: 1 is two's-complement, 0 is unsigned.
- Sum  out  WIDTH  registered result.
- Carry  out  1  raw carry-out of the MSB; under Sub, 1 means no borrow.
- Overflow  out  1  mode-dependent overflow flag for Sum.
- Valid  out  1  Sum, Carry and Overflow hold a result.
- Accept  in  1  the downstream consumer takes the result on an edge where Valid && Accept.

## Operation
- On capture, stage 1 latches:
  - A and B^{WIDTH{Sub}};
  - carry-in = Sub;
  - Sub and Signed.
- Stage k (k = 1..STAGES) does the following:
  - resolves chunk k−1 (bits [k·CHUNK−1 : (k−1)·CHUNK]) using the carry from stage k−1;
  - registers the resolved chunk, the carry out, and all not-yet-resolved operand bits;
  - passes the already-resolved lower chunks forward.
- The final stage also registers the carry into the MSB (cmsb) for signed overflow.
- Overflow is defined as follows:
  - Signed=1: Overflow = cmsb ^ Carry.
  - Signed=0, Sub=0: Overflow = Carry.
  - Signed=0, Sub=1: Overflow = !Carry (borrow).
- Per-stage valid bits travel with the data. Results leave in issue order.
- Stall is global. While Valid && !Accept, every stage register, including its valid bit, holds its value and Ready = 0.
- While stalled, inputs are ignored: En with Ready=0 has no effect and the operation is not queued.
- Bubbles are not collapsed during a stall.
- The arithmetic is modulo 2^WIDTH. No saturation.

## Timing
- Latency is STAGES cycles.
  - An operation captured at edge t presents Valid=1 with its result after edge t+STAGES−1.
  - With STAGES=1, the result is visible after the capture edge itself.
- Throughput is 1 op/cycle while Accept=1.
- Sum, Carry, Overflow and Valid are registered. Ready is the only combinational output, and it depends only on Accept and Valid.
- Reset (edge with Reset=1):
  - every stage valid bit goes to 0;
  - Sum=0, Carry=0, Overflow=0, Valid=0;
  - Ready=1 after reset, and Ready follows Accept || !Valid combinationally, including during the reset cycle;
  - Reset has priority over En and Accept: inputs present on a reset edge are discarded;
  - reset mid-flight drops every in-flight operation, and no stale result appears afterwards.
- Simultaneous events:
  - Accept and a new En capture in the same cycle: the pipeline advances, the output result is consumed, and the new op enters stage 1.
  - When Valid=0, Sum/Carry/Overflow keep their last values. Consumers must qualify them with Valid.

## Structure
- Shared package adder_pkg holds:
  - the default WIDTH and CHUNK;
  - the op encoding constants OP_ADD=0 and OP_SUB=1;
  - the mode constants MODE_UNSIGNED=0 and MODE_SIGNED=1.
- Sub-module adder_stage is a single CHUNK-wide slice. It has:
  - a chunk adder;
  - carry-in/out;
  - stall-gated registers for the resolved result, the remaining operands and the valid bit.
- pipe_adder instantiates STAGES copies of adder_stage with a generate loop and adds the overflow/flag logic and Ready.

## Test plan
Bench configuration is WIDTH=8, CHUNK=4 (STAGES=2) unless noted.
- 0x0F+0x01, Sub=0, Signed=0 → one cycle after the capture edge: Sum=0x10, Carry=0, Overflow=0, Valid=1.
- 0x7F+0x01:
  - Signed=1 → Sum=0x80, Overflow=1.
  - Same operands, Signed=0 → Overflow=0, Carry=0.
- 0x00−0x01, Sub=1:
  - → Sum=0xFF, Carry=0.
  - Signed=0 → Overflow=1.
  - Signed=1 → Overflow=0.
- Four ops issued on consecutive edges with Accept=1 (0x01+0x01, 0xFF+0x01, 0x80−0x01, 0x33+0x44) → Sum sequence 0x02, 0x00 (Carry=1), 0x7F, 0x77 on consecutive cycles, in order.
- Backpressure:
  - Hold Accept=0 when Valid first rises → Ready=0, Sum stays stable for 3 cycles, and an En pulse during the stall is not captured.
  - Raise Accept → the remaining in-flight results appear in order, with none lost or duplicated.
- Reset with two ops in flight → after the reset edge: Valid=0, Sum=0, Ready=1, and no result emerges during the following 4 cycles. Repeat with STAGES=1 (WIDTH=8, CHUNK=8).
